// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: default sizing, the word-address type
// and the helper that turns a byte address into a word address.
package store_buffer_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 32;

  typedef logic [SB_AW-3:0] word_addr_t;

  function automatic word_addr_t word_addr(input logic [SB_AW-1:0] byte_addr);
    return byte_addr[SB_AW-1:2];
  endfunction

endpackage

// File: rtl/sb_fwd_select.sv
// Picks the youngest valid entry whose address matches the load.
// An entry is valid when its age offset from head is below count.
module sb_fwd_select #(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] match,
  input  logic [PW-1:0]    head,
  input  logic [PW:0]      count,
  output logic             hit,
  output logic [PW-1:0]    idx
);

  logic [PW-1:0] pos;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    pos = '0;
    for (int k = 0; k < DEPTH; k++) begin
      pos = head + PW'(k);
      if (((PW+1)'(k) < count) && match[pos]) begin
        hit = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Word-granular store buffer: queues stores, drains them in order on cycles
// with no load, and forwards the youngest matching store to loads.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          st_valid,
  input  logic [AW-1:0] st_addr,
  input  logic [DW-1:0] st_data,
  output logic          st_ready,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  output logic [DW-1:0] ld_data,
  output logic          ld_fwd,
  output logic          empty,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_wdata,
  output logic          dm_MemWrite,
  input  logic [DW-1:0] dm_rdata
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] head, tail;
  logic [PW:0]   count;
  logic [AW-3:0] ent_addr [DEPTH];
  logic [DW-1:0] ent_data [DEPTH];

  logic [AW-3:0]    st_waddr, ld_waddr;
  logic [DEPTH-1:0] match;
  logic             hit;
  logic [PW-1:0]    hit_idx;
  logic             accept, drain;

  if (AW == SB_AW) begin : g_pkg_addr
    assign st_waddr = word_addr(st_addr);
    assign ld_waddr = word_addr(ld_addr);
  end else begin : g_raw_addr
    assign st_waddr = st_addr[AW-1:2];
    assign ld_waddr = ld_addr[AW-1:2];
  end

  // Handshake: a store transfers on any edge where st_valid && st_ready; st_ready
  // is a pure function of registered count, so it never depends on this cycle's
  // drain or load.
  assign st_ready = (count != (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign accept   = st_valid && st_ready;
  assign drain    = !ld_valid && (count != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (accept) tail <= tail + PW'(1);
      if (drain)  head <= head + PW'(1);
      case ({accept, drain})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry payload needs no reset: validity is carried by head/count alone.
  always_ff @(posedge clk) begin
    if (accept) begin
      ent_addr[tail] <= st_waddr;
      ent_data[tail] <= st_data;
    end
  end

  always_comb begin
    dm_addr     = '0;
    dm_wdata    = ent_data[head];
    dm_MemWrite = 1'b0;
    if (ld_valid) begin
      dm_addr = ld_addr;
    end else if (count != '0) begin
      dm_addr     = {ent_addr[head], 2'b00};
      dm_MemWrite = 1'b1;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    assign match[i] = (ent_addr[i] == ld_waddr);
  end

  sb_fwd_select #(.DEPTH(DEPTH), .PW(PW)) u_fwd_select (
    .match (match),
    .head  (head),
    .count (count),
    .hit   (hit),
    .idx   (hit_idx)
  );

  assign ld_fwd  = ld_valid && hit;
  assign ld_data = hit ? ent_data[hit_idx] : dm_rdata;

endmodule

// File: tb/tb_store_buffer.sv
// Randomized and directed scoreboard bench for store_buffer, with a queue-based
// reference model of the pending stores and the data memory.
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        st_valid, ld_valid, st_ready, ld_fwd, empty, dm_MemWrite;
  logic [31:0] st_addr, st_data, ld_addr, ld_data, dm_addr, dm_wdata, dm_rdata;
  logic        preload;

  store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .st_valid    (st_valid),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_ready    (st_ready),
    .ld_valid    (ld_valid),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_fwd      (ld_fwd),
    .empty       (empty),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_MemWrite (dm_MemWrite),
    .dm_rdata    (dm_rdata)
  );

  // ---------------- clock / reset / memory environment ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] seed_word(input int i);
    return 32'hA500_0000 | (i * 32'h111);
  endfunction

  logic [31:0] env_mem [64];
  assign dm_rdata = env_mem[dm_addr[7:2]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) env_mem[i] <= seed_word(i);
    end else if (dm_MemWrite) begin
      env_mem[dm_addr[7:2]] <= dm_wdata;
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    word_addr_t  wa;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] ref_mem [64];
  logic        pend_drain, pend_acc;
  word_addr_t  pend_wa;
  logic [31:0] pend_d;

  typedef struct packed {
    logic        st_ready;
    logic        empty;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_ld;
    logic        ld_fwd;
    logic [31:0] ld_data;
  } exp_t;

  exp_t exp_q[$];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  // Apply the effect of the edge that just happened: oldest store retires, new store queues.
  task automatic commit();
    if (pend_drain && mq.size() > 0) begin
      ref_mem[mq[0].wa[5:0]] = mq[0].d;
      void'(mq.pop_front());
    end
    if (pend_acc) mq.push_back('{wa: pend_wa, d: pend_d});
    pend_drain = 1'b0;
    pend_acc   = 1'b0;
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                      input logic lv, input logic [31:0] la);
    exp_t e;
    logic found;
    logic [31:0] fd;
    @(posedge clk);
    commit();
    #1;
    st_valid = sv; st_addr = sa; st_data = sd;
    ld_valid = lv; ld_addr = la;
    found = 1'b0;
    fd    = '0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (!found && mq[i].wa == word_addr(la)) begin
        found = 1'b1;
        fd    = mq[i].d;
      end
    end
    e.st_ready  = (mq.size() != DEPTH);
    e.empty     = (mq.size() == 0);
    e.mem_write = !lv && (mq.size() > 0);
    e.addr      = lv ? la : (mq.size() > 0 ? {mq[0].wa, 2'b00} : 32'h0);
    e.wdata     = (mq.size() > 0) ? mq[0].d : 32'h0;
    e.chk_ld    = lv;
    e.ld_fwd    = found;
    e.ld_data   = found ? fd : ref_mem[la[7:2]];
    pend_drain  = e.mem_write;
    pend_acc    = sv && e.st_ready;
    pend_wa     = word_addr(sa);
    pend_d      = sd;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_st_ready"}, {31'b0, st_ready}, 32'd1);
    check({tag, "_empty"}, {31'b0, empty}, 32'd1);
    check({tag, "_memwrite"}, {31'b0, dm_MemWrite}, 32'd0);
    check({tag, "_ld_fwd"}, {31'b0, ld_fwd}, 32'd0);
  endtask

  // Asserts reset in the middle of a cycle, discarding everything queued.
  task automatic mid_reset();
    @(posedge clk);
    commit();
    #1;
    st_valid = 1'b0;
    ld_valid = 1'b0;
    #1 reset = 1'b0;
    #1 check_reset_outputs("midrst");
    mq.delete();
    @(posedge clk);
    #1;
    check("midrst_hold_memwrite", {31'b0, dm_MemWrite}, 32'd0);
    reset = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("st_ready", {31'b0, st_ready}, {31'b0, e.st_ready});
      check("empty", {31'b0, empty}, {31'b0, e.empty});
      check("dm_MemWrite", {31'b0, dm_MemWrite}, {31'b0, e.mem_write});
      check("dm_addr", dm_addr, e.addr);
      if (e.mem_write) check("dm_wdata", dm_wdata, e.wdata);
      if (e.chk_ld) begin
        check("ld_fwd", {31'b0, ld_fwd}, {31'b0, e.ld_fwd});
        check("ld_data", ld_data, e.ld_data);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [31:0] d5;
    reset = 1'b0; preload = 1'b1;
    st_valid = 1'b0; ld_valid = 1'b0;
    st_addr = '0; st_data = '0; ld_addr = '0;
    pend_drain = 1'b0; pend_acc = 1'b0; pend_wa = '0; pend_d = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = seed_word(i);
    #3 check_reset_outputs("por");
    @(posedge clk);
    @(posedge clk);
    #1 preload = 1'b0; reset = 1'b1;

    // single store into an idle buffer, then read it back from memory
    step(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0);
    idle(2);
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h10);

    // youngest-match forwarding while loads hold off the drain
    step(1'b1, 32'h10, 32'h1, 1'b1, 32'h14);
    step(1'b1, 32'h10, 32'h2, 1'b1, 32'h14);
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h10);
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h20);
    idle(3);

    // fill to full and past it, twice so the pointers wrap
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 4; i++) step(1'b1, 32'(i * 4), $urandom, 1'b1, 32'h80);
      d5 = $urandom;
      step(1'b1, 32'h30, d5, 1'b1, 32'h80);
      step(1'b1, 32'h30, d5, 1'b0, 32'h0);
      step(1'b1, 32'h30, d5, 1'b0, 32'h0);
      idle(6);
    end

    // drain and accept in the same cycle at count 2
    step(1'b1, 32'h40, 32'h1111_0000, 1'b1, 32'h44);
    step(1'b1, 32'h48, 32'h2222_0000, 1'b1, 32'h44);
    step(1'b1, 32'h4C, 32'h3333_0000, 1'b0, 32'h0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h48);
    idle(4);

    // byte offset bits are ignored on both store and load
    step(1'b1, 32'h13, 32'hCAFE_F00D, 1'b1, 32'h50);
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h10);
    idle(2);

    // reset with stores pending: they must never reach memory
    step(1'b1, 32'h60, 32'h6060_6060, 1'b1, 32'h64);
    step(1'b1, 32'h68, 32'h6868_6868, 1'b1, 32'h64);
    mid_reset();
    idle(3);
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h60);

    // random traffic, mostly exclusive store/load with occasional overlap
    for (int i = 0; i < 600; i++) begin
      int r;
      logic sv, lv;
      r  = $urandom_range(0, 99);
      sv = (r < 45) || (r >= 95);
      lv = (r >= 45 && r < 85) || (r >= 95);
      step(sv, 32'($urandom_range(0, 255)), $urandom, lv, 32'($urandom_range(0, 255)));
    end
    idle(8);
    @(posedge clk);
    #6;
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Word-granular store buffer between the MEM stage and the single-port data memory. It queues up to DEPTH pending stores so the pipeline does not wait on memory writes. Queued stores drain into the memory one per idle cycle, in program order. Loads arriving from the MEM stage get the youngest matching buffered store by forwarding; on a miss they read memory directly.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥2
- AW, 32, byte-address width
- DW, 32, data width

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low; clears all entries
- st_valid  in  1  MEM stage issues a word store
- st_addr  in  AW  store byte address; bits [1:0] ignored
- st_data  in  DW  store data
- st_ready  out  1  buffer can accept a store; when low the MEM stage stalls
- ld_valid  in  1  MEM stage issues a word load
- ld_addr  in  AW  load byte address
- ld_data  out  DW  load result, combinational in the same cycle
- ld_fwd  out  1  ld_data came from the buffer (debug/perf)
- empty  out  1  no pending stores; the CPU waits on it before halt or syscall
- dm_addr  out  AW  address to data memory
- dm_wdata  out  DW  write data to data memory
- dm_MemWrite  out  1  memory write enable, sampled by memory at posedge clk
- dm_rdata  in  DW  combinational read data from memory

## Operation
- **Storage**
  - Circular FIFO of {word address AW-2 bits, data DW bits}.
  - head and tail pointers are log2(DEPTH) bits and wrap naturally.
  - count is log2(DEPTH)+1 bits.
- **Accept**
  - A store is accepted when st_valid && st_ready. It is written at tail, and tail advances.
  - st_ready = (count != DEPTH). It depends only on registered state, with no path from the drain logic.
- **Memory port arbitration (combinational)**
  - If ld_valid: dm_addr = ld_addr, dm_MemWrite = 0. Loads own the port.
  - Else if count > 0: dm_addr = {head word address, 2'b00}, dm_wdata = head data, dm_MemWrite = 1. The head pops at posedge.
  - Else: dm_MemWrite = 0, dm_addr = 0.
- **Forwarding**
  - Compare ld_addr[AW-1:2] against every valid entry.
  - On a match, ld_data = data of the youngest matching entry (closest to tail) and ld_fwd = 1.
  - Otherwise ld_data = dm_rdata and ld_fwd = 0.
- **Count update:** +1 on accept only, −1 on drain only, unchanged when both happen in the same cycle.
- **Simultaneous st_valid and ld_valid**
  - The MEM stage never produces this. If it occurs, the store is still accepted, and the load is served from the pre-accept buffer state plus memory.
- **Full while storing:** st_ready = 0, so the store stalls. Since no load is present, the head drains in that cycle and st_ready rises the next cycle.
- empty = (count == 0).

## Timing
- **Reset:** asynchronous, active-low. All outputs take these values immediately:
  - count = 0, head = tail = 0, st_ready = 1, empty = 1
  - dm_MemWrite = 0, ld_fwd = 0
  - Entry contents are don't-care.
- **Reset mid-operation:** all pending stores are discarded and never reach memory. This is intended.
- **Store latency:** a store accepted at edge T drives dm_MemWrite during cycle T→T+1 (if no load) and is committed to memory at edge T+1.
- **Load latency:** zero cycles; ld_data is valid in the cycle ld_valid is high.
- A store accepted at edge T is forwardable to a load in cycle T→T+1.
- **Drain starvation:** every consecutive ld_valid cycle delays the drain. Drain order is always FIFO.

## Structure
- A shared package holds the default DEPTH, the word-address type, and a word_addr(byte_addr) function that drops bits [1:0].
- The youngest-match priority selector is split into a sub-module, sb_fwd_select.
  - Inputs: per-entry match vector, head, count.
  - Outputs: hit and the selected index.
- Pointer, count and arbitration logic stay in store_buffer.

## Test plan
- **Reset:** reset low during activity → st_ready=1, empty=1, dm_MemWrite=0 immediately. Previously queued stores never appear on dm_MemWrite.
- **Single store, idle:** store 0xDEADBEEF to 0x10 → next cycle dm_MemWrite=1, dm_addr=0x10; memory word 4 = 0xDEADBEEF; empty=1 after.
- **Forward youngest:** back-to-back stores 0x10←1, 0x10←2 under continuous loads of 0x14, then load 0x10 → ld_data=2, ld_fwd=1. Load 0x20 → ld_fwd=0, ld_data=dm_rdata.
- **Full and wrap:** hold ld_valid to block drain, issue 5 stores with DEPTH=4 → st_ready=0 after the 4th. Release loads → drain order is addresses 0,4,8,C. 5th store accepted the cycle after the first drain. Repeat past a pointer wrap with the same result.
- **Drain + accept same cycle:** count=2, no load, new store → count stays 2, FIFO order preserved.
- **Byte-offset aliasing:** store to 0x13, load from 0x10 → hit, forwarded data.
